// File: rtl/alu_ctrl_if.sv
// Request channel from the instruction sequencer into the ALU control-word encoder.
// The master is the sequencer and the slave is the encoder.
interface alu_ctrl_if #(
    parameter int unsigned CNT_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [CNT_W-1:0] req_shamt;

    modport master (
        output req_valid,
        output req_op,
        output req_shamt,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_shamt,
        output req_ready
    );
endinterface

// File: rtl/alu_ctrl_encoder.sv
// Maps ALU op requests to the 6-bit control word (Ctrl0..Ctrl5). Multi-bit shifts and
// rotates are expanded into repeated single-bit steps, and each step is strobed by alu_we.
module alu_ctrl_encoder #(
    parameter int unsigned CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    alu_ctrl_if.slave  req,
    output logic       Ctrl0,
    output logic       Ctrl1,
    output logic       Ctrl2,
    output logic       Ctrl3,
    output logic       Ctrl4,
    output logic       Ctrl5,
    output logic       alu_we,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [0:0] {StIdle, StExec} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [5:0]       ctrl_q;
    logic             alu_we_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic             is_shift;
    logic             is_illegal;
    logic [CNT_W-1:0] load_cnt;

    // Control word packed with Ctrl0 in bit 5, so literals read in Ctrl0..Ctrl5 order.
    function automatic logic [5:0] op_word(input logic [3:0] op);
        logic [5:0] w;
        case (op)
            4'd0:    w = 6'b010010;
            4'd1:    w = 6'b010001;
            4'd2:    w = 6'b001010;
            4'd3:    w = 6'b001100;
            4'd4:    w = 6'b001110;
            4'd5:    w = 6'b000110;
            4'd6:    w = 6'b000000;
            4'd7:    w = 6'b011011;
            4'd8:    w = 6'b011000;
            4'd9:    w = 6'b100100;
            4'd10:   w = 6'b100000;
            4'd11:   w = 6'b100010;
            4'd12:   w = 6'b101100;
            4'd13:   w = 6'b101000;
            4'd14:   w = 6'b101010;
            default: w = 6'b000000;
        endcase
        return w;
    endfunction

    always_comb begin
        is_illegal = (req.req_op == 4'd15);
        is_shift   = (req.req_op >= 4'd9) && !is_illegal;
        load_cnt   = is_shift ? req.req_shamt : CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            ctrl_q   <= '0;
            alu_we_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    ctrl_q   <= '0;
                    alu_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    err_q    <= 1'b0;
                    if (req.req_valid) begin
                        if (is_illegal) begin
                            err_q <= 1'b1;
                        end else if (load_cnt == '0) begin
                            // Zero-step shift: acknowledge without touching the ALU.
                            done_q <= 1'b1;
                        end else begin
                            state_q  <= StExec;
                            cnt_q    <= load_cnt;
                            ctrl_q   <= op_word(req.req_op);
                            alu_we_q <= 1'b1;
                            busy_q   <= 1'b1;
                            done_q   <= (load_cnt == CNT_W'(1));
                        end
                    end
                end
                StExec: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q  <= StIdle;
                        cnt_q    <= '0;
                        ctrl_q   <= '0;
                        alu_we_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_q - CNT_W'(1);
                        done_q <= (cnt_q == CNT_W'(2));
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req.req_ready = (state_q == StIdle) && !rst;

    assign {Ctrl0, Ctrl1, Ctrl2, Ctrl3, Ctrl4, Ctrl5} = ctrl_q;
    assign alu_we = alu_we_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_alu_ctrl_encoder.sv
// Directed bench for alu_ctrl_encoder: drives requests through the interface and checks
// the registered outputs 1 ns after each rising edge against hand-computed values.
module tb_alu_ctrl_encoder;

    logic clk = 1'b0;
    logic rst;
    logic Ctrl0, Ctrl1, Ctrl2, Ctrl3, Ctrl4, Ctrl5;
    logic alu_we, busy, done, err;

    int total = 0;
    int bad   = 0;

    alu_ctrl_if #(.CNT_W(4)) bus ();

    alu_ctrl_encoder #(.CNT_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.slave),
        .Ctrl0  (Ctrl0),
        .Ctrl1  (Ctrl1),
        .Ctrl2  (Ctrl2),
        .Ctrl3  (Ctrl3),
        .Ctrl4  (Ctrl4),
        .Ctrl5  (Ctrl5),
        .alu_we (alu_we),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected tuple: ready, ctrl word (Ctrl0..Ctrl5), alu_we, busy, done, err.
    task automatic chk(input string tag, input logic rdy, input logic [5:0] cw,
                       input logic we, input logic bz, input logic dn, input logic er);
        logic [10:0] obs;
        logic [10:0] exp;
        obs = {bus.req_ready, Ctrl0, Ctrl1, Ctrl2, Ctrl3, Ctrl4, Ctrl5, alu_we, busy, done, err};
        exp = {rdy, cw, we, bz, dn, er};
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s obs=%b expected=%b (rdy,ctrl,we,busy,done,err)", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] sh);
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_shamt = sh;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'd0, 4'd0);
        tick();
        tick();
        chk("reset_hold", 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("reset_release", 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);

        // SRL x5 abandoned by a 2-cycle reset mid-op.
        drive(1'b1, 4'd13, 4'd5);
        tick();
        drive(1'b0, 4'd0, 4'd0);
        chk("srl_step1", 1'b0, 6'b101000, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("srl_step2", 1'b0, 6'b101000, 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        chk("srl_rst1", 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("srl_rst2", 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("srl_release", 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("srl_no_done", 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);

        // ADD, SUB, XOR with valid held high; each waits for req_ready.
        drive(1'b1, 4'd0, 4'd0);
        tick();
        chk("add_step", 1'b0, 6'b010010, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 4'd1, 4'd0);
        tick();
        chk("add_gap", 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("sub_step", 1'b0, 6'b010001, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 4'd4, 4'd0);
        tick();
        chk("sub_gap", 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("xor_step", 1'b0, 6'b001110, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 4'd0, 4'd0);
        tick();
        chk("xor_gap", 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);

        // ROL x3.
        drive(1'b1, 4'd11, 4'd3);
        tick();
        drive(1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rol_step%0d", i + 1), 1'b0, 6'b100010, 1'b1, 1'b1, (i == 2), 1'b0);
            tick();
        end
        chk("rol_idle", 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);

        // SRA x15: maximum count, no wrap.
        drive(1'b1, 4'd12, 4'd15);
        tick();
        drive(1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("sra_step%0d", i + 1), 1'b0, 6'b101100, 1'b1, 1'b1, (i == 14), 1'b0);
            tick();
        end
        chk("sra_idle", 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("sra_idle2", 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);

        // SLL x0 then illegal op, accepted on consecutive edges.
        drive(1'b1, 4'd10, 4'd0);
        tick();
        drive(1'b1, 4'd15, 4'd7);
        chk("sll0_done", 1'b1, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 4'd0, 4'd0);
        chk("illegal_err", 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("illegal_idle", 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);

        // SLA x4 with request inputs churning during EXEC.
        drive(1'b1, 4'd9, 4'd4);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(1'b1, 4'(i * 5 + 1), 4'(i + 9));
            else drive(1'b0, 4'd2, 4'd1);
            chk($sformatf("sla_step%0d", i + 1), 1'b0, 6'b100100, 1'b1, 1'b1, (i == 3), 1'b0);
            tick();
        end
        chk("sla_idle", 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_encoder.md
# alu_ctrl_encoder

Control-word sequencer that drives the six ALU control lines (Ctrl0..Ctrl5) consumed by the ALU6 control decoder. It accepts an operation request from the instruction sequencer over a valid/ready handshake and maps the operation to its 6-bit control word. Multi-bit shifts and rotates are expanded into repeated single-bit ALU steps. Each ALU step is strobed for accumulator writeback. It sits between the instruction decode stage and the ALU control decoder.

## Interface
- CNT_W, 4, width of the shift-amount field; a request performs at most 2^CNT_W-1 steps.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_op  in  4  operation code: 0 ADD, 1 SUB, 2 OR, 3 NOT, 4 XOR, 5 AND, 6 MOV, 7 INC, 8 DEC, 9 SLA, 10 SLL, 11 ROL, 12 SRA, 13 SRL, 14 ROR, 15 illegal.
- req_shamt  in  CNT_W  step count; used only for ops 9-14.
- Ctrl0..Ctrl5  out  1 each  ALU control word, registered.
- alu_we  out  1  ALU result writeback strobe for the current step.
- busy  out  1  high while in EXEC.
- done  out  1  one-cycle pulse on the final step of an op, or on a zero-step op.
- err  out  1  one-cycle pulse when req_op = 15 is accepted.

## Operation
- Control words are listed as Ctrl0..Ctrl5:
  - ADD 010010, SUB 010001, OR 001010, NOT 001100, XOR 001110, AND 000110, MOV 000000, INC 011011, DEC 011000.
  - SLA 100100, SLL 100000, ROL 100010, SRA 101100, SRL 101000, ROR 101010.
- The idle control word is MOV (000000) with alu_we=0.
- FSM states are IDLE and EXEC:
  - IDLE: req_ready=1. A request is accepted when req_valid=1 and req_ready=1 at a rising edge.
  - Accepted ops 0-8 load step count 1 and go to EXEC.
  - Accepted ops 9-14 with shamt>0 load step count = shamt and go to EXEC.
  - Accepted ops 9-14 with shamt=0 stay in IDLE and pulse done next cycle, with alu_we=0 and the control word held at MOV.
  - Accepted op 15 stays in IDLE and pulses err next cycle. No alu_we, no done, control word held at MOV.
  - EXEC: drive the latched op's control word, alu_we=1, busy=1. Decrement the count each cycle.
  - EXEC with count==1: done=1 in that cycle, and the next state is IDLE.
- The op code and count are latched at acceptance. Input changes during EXEC are ignored.
- The step counter is CNT_W bits wide and never wraps, because the maximum load is 2^CNT_W-1.

## Timing
- Reset values: state IDLE, Ctrl0..Ctrl5=000000, alu_we=0, busy=0, done=0, err=0, req_ready=1 (once reset has been released).
- rst high at any edge forces the reset state at that edge, including mid-EXEC. An in-progress op is abandoned with no done pulse.
- req_ready=0 while rst is high.
- Request accepted at edge N:
  - The first step appears in cycle N+1, with Ctrl word and alu_we valid after edge N.
  - A k-step op occupies cycles N+1..N+k.
  - done is high in cycle N+k.
  - The block is back in IDLE in cycle N+k+1.
- Back-to-back: the next request can be accepted no earlier than edge N+k+1. This gives one idle cycle, with Ctrl=000000 and alu_we=0, between ops.
- Zero-step and illegal requests give a done or err pulse in cycle N+1. req_ready stays 1, so acceptance every cycle is allowed.
- done and err are never high together. done is high only together with alu_we=1, or on a zero-step op.

## Test plan
- Reset: hold rst for 2 cycles during a 5-step SRL -> all outputs at reset values, no done pulse; after release, req_ready=1 and Ctrl=000000.
- Single-cycle ops: ADD, then SUB, then XOR, each accepted as soon as req_ready returns -> one cycle each of Ctrl 010010, 010001, 001110 with alu_we=1 and done=1, separated by single idle cycles at 000000.
- Multi-step shift: ROL with shamt=3 -> 3 consecutive cycles of Ctrl 100010 with alu_we=1, busy=1; done only in cycle 3; req_ready=0 for those 3 cycles.
- Maximum count: SRA with shamt=15 -> exactly 15 steps of 101100, then IDLE; no wrap and no extra step.
- Boundary requests: SLL with shamt=0 -> done pulse next cycle, alu_we never high. req_op=15 -> err pulse next cycle, Ctrl stays 000000.
- Input stability: change req_op and req_shamt every cycle during a 4-step SLA -> the output stays 100100 for all 4 steps.
